// File: rtl/hier_leaf_fifo.sv
// Leaf streaming buffer: small first-word-fall-through FIFO between sibling
// leaf instances, with occupancy count and full/empty flags.
module hier_leaf_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;
  logic w_clear;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_clear = !rst_n || i_flush;

  // Ready comes only from registered state, so no valid->ready path upstream.
  assign o_in_ready  = rst_n && !w_full;
  assign o_out_valid = !w_empty;
  assign o_out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;

  assign w_wr = i_in_valid && o_in_ready;
  assign w_rd = o_out_valid && i_out_ready;

  // Storage is never cleared; flush/reset just rewinds pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr && !w_clear) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hier_leaf_fifo.sv
// Directed self-checking bench for hier_leaf_fifo (WIDTH=8, DEPTH=4).
module tb_hier_leaf_fifo;

  logic       clk;
  logic       rst_n;
  logic       i_flush;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_data;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [7:0] o_out_data;
  logic [2:0] o_count;
  logic       o_full;
  logic       o_empty;

  int n_cmp = 0;
  int n_err = 0;

  hier_leaf_fifo #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (i_flush),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
    i_in_valid  = v;
    i_in_data   = d;
    i_out_ready = rdy;
  endtask

  logic [31:0] pat;
  int sent, rcv, mc, max_mc;
  logic w, r;

  initial begin
    rst_n = 1'b0;
    i_flush = 1'b0;
    drive(1'b1, 8'hAA, 1'b0);
    step();
    step();
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 8'h00);

    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk("rel_in_ready", o_in_ready, 1);
    step();
    chk("rel_count", o_count, 0);

    // Fill with reads stalled
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i * 8'h11), 1'b0);
      step();
      if (i == 1) chk("fill_first_visible", o_out_data, 8'h11);
    end
    chk("fill_count", o_count, 4);
    chk("fill_full", o_full, 1);
    chk("fill_in_ready", o_in_ready, 0);
    chk("fill_head", o_out_data, 8'h11);
    drive(1'b1, 8'h55, 1'b0);
    step();
    chk("full_reject_count", o_count, 4);
    chk("full_reject_head", o_out_data, 8'h11);

    // Full with a simultaneous read: read only, write lands next cycle
    drive(1'b1, 8'h55, 1'b1);
    step();
    chk("fs_count", o_count, 3);
    chk("fs_head", o_out_data, 8'h22);
    chk("fs_in_ready", o_in_ready, 1);
    drive(1'b1, 8'h55, 1'b0);
    step();
    chk("fs_count2", o_count, 4);
    chk("fs_full2", o_full, 1);

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      #1;
      chk("drain_data", o_out_data, (i == 3) ? 8'h55 : 8'((i + 2) * 8'h11));
      step();
    end
    chk("drain_empty", o_empty, 1);
    chk("drain_valid", o_out_valid, 0);
    chk("drain_data0", o_out_data, 8'h00);

    // Streaming 0x00..0x0F with a fixed stall pattern, independent count model
    pat = 32'b0000_1111_0011_1000_0111_0000_1011_0101;
    sent = 0; rcv = 0; mc = 0; max_mc = 0;
    for (int c = 0; c < 200 && rcv < 16; c++) begin
      drive(sent < 16, 8'(sent), pat[c % 32]);
      #1;
      chk("wr_in_ready", o_in_ready, (mc < 4) ? 1 : 0);
      chk("wr_out_valid", o_out_valid, (mc > 0) ? 1 : 0);
      chk("wr_count", o_count, mc);
      w = i_in_valid && (mc < 4);
      r = (mc > 0) && i_out_ready;
      if (r) chk("wr_data", o_out_data, rcv);
      step();
      if (w) sent++;
      if (r) rcv++;
      mc = mc + (w ? 1 : 0) - (r ? 1 : 0);
      if (mc > max_mc) max_mc = mc;
    end
    chk("wr_received", rcv, 16);
    chk("wr_max_count", max_mc, 4);
    chk("wr_final_empty", o_empty, 1);

    // Flush overrides a simultaneous write and read
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0);
      step();
    end
    chk("fl_pre_count", o_count, 3);
    i_flush = 1'b1;
    drive(1'b1, 8'h77, 1'b1);
    step();
    i_flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("fl_count", o_count, 0);
    chk("fl_empty", o_empty, 1);
    chk("fl_data", o_out_data, 8'h00);
    drive(1'b1, 8'h5A, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b1);
    chk("fl_next_word", o_out_data, 8'h5A);
    chk("fl_next_count", o_count, 1);
    step();
    chk("fl_post_empty", o_empty, 1);

    // Reset mid-operation
    drive(1'b1, 8'hB1, 1'b0);
    step();
    drive(1'b1, 8'hB2, 1'b0);
    step();
    chk("mr_pre_count", o_count, 2);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk("mr_in_ready_low", o_in_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_count", o_count, 0);
    chk("mr_empty", o_empty, 1);
    chk("mr_in_ready", o_in_ready, 1);
    drive(1'b1, 8'h99, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("mr_first_word", o_out_data, 8'h99);
    chk("mr_count1", o_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
